// File: rtl/piano_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piano_pkg: pitch table, envelope encoding, default sample widths.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package piano_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int AMP_MAX_DEFAULT  = 16'h3FFF;

  localparam int HP_W = 7;

  // Half-period in sample ticks, C4..C5; entry 0 is the rightmost element.
  localparam logic [7:0][HP_W-1:0] HALF_PERIOD = {
    7'd46, 7'd49, 7'd55, 7'd61, 7'd69, 7'd73, 7'd82, 7'd92
  };

  function automatic logic [HP_W-1:0] half_period(input logic [2:0] idx);
    return HALF_PERIOD[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_conditioner: synchronizes raw active-low keys, optional         |
// | debouncer (KEY_DEBOUNCE_EN), and rise/fall detection.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module key_conditioner
  import piano_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] pressed_o,
  output logic [NUM_KEYS-1:0] rise_o,
  output logic [NUM_KEYS-1:0] fall_o
);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] level_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;

    // Counts consecutive cycles the synchronized level differs from the accepted level.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else if (sync2_q[k] == level_q[k]) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(DEBOUNCE_CYC)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level_d[k] = ((sync2_q[k] != level_q[k]) && (cnt_q == CNT_W'(DEBOUNCE_CYC)))
                        ? sync2_q[k] : level_q[k];
  end
`else
  assign level_d = sync2_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign pressed_o = level_d;
  assign rise_o    = level_d & ~level_q;
  assign fall_o    = ~level_d & level_q;

endmodule
`default_nettype wire

// File: rtl/key_voice_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_voice_scheduler: last-pressed-wins key arbitration, square tone |
// | with ADSR-style envelope, valid/ready sample output.               |
// | Optional KEY_DEBOUNCE_EN builds the key debouncer.  Revision: 1.0  |
// +--------------------------------------------------------------------+
module key_voice_scheduler
  import piano_pkg::*;
#(
  parameter  int NUM_KEYS     = 4,
  parameter  int SAMPLE_W     = SAMPLE_W_DEFAULT,
  parameter  int AMP_MAX      = AMP_MAX_DEFAULT,
  parameter  int ENV_STEP     = 64,
  parameter  int DEBOUNCE_CYC = 500000,
  localparam int KEY_W        = $clog2(NUM_KEYS)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_KEYS-1:0]        key_n,
  input  logic                       sample_tick,
  input  logic                       sample_ready,
  output logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic [KEY_W-1:0]           cur_key,
  output logic                       note_active,
  output logic [1:0]                 env_state,
  output logic                       overrun
);

  localparam logic [SAMPLE_W:0]   AMP_MAX_X = (SAMPLE_W+1)'(AMP_MAX);
  localparam logic [SAMPLE_W:0]   STEP_X    = (SAMPLE_W+1)'(ENV_STEP);
  localparam logic [SAMPLE_W-1:0] AMP_MAX_S = SAMPLE_W'(AMP_MAX);
  localparam logic [SAMPLE_W-1:0] STEP_S    = SAMPLE_W'(ENV_STEP);

  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  key_conditioner #(
    .NUM_KEYS     (NUM_KEYS),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_conditioner (
    .clk       (clk),
    .resetn    (resetn),
    .key_n_i   (key_n),
    .pressed_o (pressed),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  logic [KEY_W-1:0]    cur_key_q, cur_key_d;
  env_state_t          env_q, env_d, env_evt;
  logic [SAMPLE_W-1:0] amp_q, amp_d;
  logic [HP_W-1:0]     phase_q, phase_d;
  logic                pol_q, pol_d;
  logic                valid_q;
  logic [SAMPLE_W-1:0] data_q;
  logic                overrun_q;

  logic [KEY_W-1:0]    rise_idx;
  logic [KEY_W-1:0]    held_idx;
  logic                any_rise;
  logic                any_held;
  logic [HP_W-1:0]     hp;
  logic [SAMPLE_W:0]   amp_sum;
  logic [SAMPLE_W-1:0] tone;

  // Ascending scan: the highest set index ends up winning.
  always_comb begin
    rise_idx = '0;
    held_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (rise[k])    rise_idx = KEY_W'(k);
      if (pressed[k]) held_idx = KEY_W'(k);
    end
  end

  assign any_rise = |rise;
  assign any_held = |pressed;

  always_comb begin
    cur_key_d = cur_key_q;
    if (any_rise) begin
      cur_key_d = rise_idx;
    end else if (fall[cur_key_q] && any_held) begin
      cur_key_d = held_idx;
    end
  end

  assign hp = half_period(3'(cur_key_d));

  always_comb begin
    phase_d = phase_q;
    pol_d   = pol_q;
    if (sample_tick) begin
      if (phase_q >= hp - HP_W'(1)) begin
        phase_d = '0;
        pol_d   = ~pol_q;
      end else begin
        phase_d = phase_q + HP_W'(1);
      end
    end
  end

  // Key events move the envelope immediately; the amplitude step then runs on the resulting state.
  always_comb begin
    env_evt = env_q;
    case (env_q)
      ENV_IDLE, ENV_RELEASE: if (any_rise) env_evt = ENV_ATTACK;
      ENV_ATTACK, ENV_SUSTAIN: if (!any_held) env_evt = ENV_RELEASE;
      default: env_evt = env_q;
    endcase

    env_d   = env_evt;
    amp_d   = amp_q;
    amp_sum = {1'b0, amp_q} + STEP_X;
    if (sample_tick) begin
      case (env_evt)
        ENV_IDLE: amp_d = '0;
        ENV_ATTACK: begin
          if (amp_sum >= AMP_MAX_X) begin
            amp_d = AMP_MAX_S;
            env_d = ENV_SUSTAIN;
          end else begin
            amp_d = amp_sum[SAMPLE_W-1:0];
          end
        end
        ENV_RELEASE: begin
          if ({1'b0, amp_q} <= STEP_X) begin
            amp_d = '0;
            env_d = ENV_IDLE;
          end else begin
            amp_d = amp_q - STEP_S;
          end
        end
        default: amp_d = amp_q;
      endcase
    end
  end

  assign tone = pol_d ? amp_d : -amp_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_key_q <= '0;
      env_q     <= ENV_IDLE;
      amp_q     <= '0;
      phase_q   <= '0;
      pol_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      cur_key_q <= cur_key_d;
      env_q     <= env_d;
      amp_q     <= amp_d;
      phase_q   <= phase_d;
      pol_q     <= pol_d;
      if (sample_tick) begin
        valid_q <= 1'b1;
        data_q  <= tone;
        if (valid_q && !sample_ready) overrun_q <= 1'b1;
      end else if (sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign cur_key      = cur_key_q;
  assign note_active  = (env_q != ENV_IDLE);
  assign env_state    = env_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_key_voice_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_voice_scheduler: randomized bench with a behavioural model  |
// | of the key voice scheduler.  Revision: 1.0                         |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_key_voice_scheduler;
  import piano_pkg::*;

  localparam int NK     = 4;
  localparam int W      = 16;
  localparam int AMPMAX = 16'h3FFF;
  localparam int STEP   = 64;
`ifdef KEY_DEBOUNCE_EN
  localparam int DEB    = 10;
`else
  localparam int DEB    = 500000;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic          sample_tick = 1'b0;
  logic          sample_ready = 1'b1;
  logic          sample_valid;
  logic signed [W-1:0] sample_data;
  logic [1:0]    cur_key;
  logic          note_active;
  logic [1:0]    env_state;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int gap_left = 3;

  always #5 clk = ~clk;

  key_voice_scheduler #(
    .NUM_KEYS     (NK),
    .SAMPLE_W     (W),
    .AMP_MAX      (AMPMAX),
    .ENV_STEP     (STEP),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .key_n        (key_n),
    .sample_tick  (sample_tick),
    .sample_ready (sample_ready),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .cur_key      (cur_key),
    .note_active  (note_active),
    .env_state    (env_state),
    .overrun      (overrun)
  );

  // Behavioural model: key levels seen by the arbiter lag the pins by two clock edges.
  int            hp_tab [8] = '{92, 82, 73, 69, 61, 55, 49, 46};
  logic [NK-1:0] hist [4];
  int            m_cur, m_st, m_amp, m_phase, m_data;
  bit            m_pol, m_valid, m_over;

  function automatic int top_bit(input logic [NK-1:0] v);
    int r = 0;
    for (int i = 0; i < NK; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    m_cur = 0; m_st = 0; m_amp = 0; m_phase = 0; m_data = 0;
    m_pol = 1'b0; m_valid = 1'b0; m_over = 1'b0;
  endtask

  task automatic model_step();
    logic [NK-1:0] now_l, prev_l, rise, fall;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ~key_n;
    now_l  = hist[2];
    prev_l = hist[3];
    rise   = now_l & ~prev_l;
    fall   = prev_l & ~now_l;
    if (rise != 0) m_cur = top_bit(rise);
    else if (fall[m_cur] && now_l != 0) m_cur = top_bit(now_l);
    if ((m_st == 0 || m_st == 3) && rise != 0) m_st = 1;
    else if ((m_st == 1 || m_st == 2) && now_l == 0) m_st = 3;
    if (sample_tick) begin
      if (m_phase >= hp_tab[m_cur] - 1) begin
        m_phase = 0;
        m_pol   = !m_pol;
      end else begin
        m_phase++;
      end
      case (m_st)
        0: m_amp = 0;
        1: begin
          m_amp = (m_amp + STEP >= AMPMAX) ? AMPMAX : m_amp + STEP;
          if (m_amp == AMPMAX) m_st = 2;
        end
        3: begin
          m_amp = (m_amp <= STEP) ? 0 : m_amp - STEP;
          if (m_amp == 0) m_st = 0;
        end
        default: ;
      endcase
      if (m_valid && !sample_ready) m_over = 1'b1;
      m_valid = 1'b1;
      m_data  = m_pol ? m_amp : -m_amp;
    end else if (sample_ready) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [22:0] obs_vec();
    return {cur_key, env_state, note_active, sample_valid, sample_data, overrun};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {2'(m_cur), 2'(m_st), (m_st != 0), m_valid, 16'(m_data), m_over};
  endfunction

  task automatic gen_tick(output bit tk);
    if (gap_left <= 0) begin
      tk = 1'b1;
      gap_left = $urandom_range(2, 7);
    end else begin
      tk = 1'b0;
      gap_left--;
    end
  endtask

  task automatic step(input bit tk, input bit rdy);
    sample_tick  = tk;
    sample_ready = rdy;
    @(posedge clk);
    if (resetn) model_step();
    #1 sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    bit tk;
    resetn = 1'b0;
    key_n  = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    resetn = 1'b1;
    for (int c = 0; c < 300; c++) begin
      gen_tick(tk);
      step(tk, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL idle_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (tk) begin
        n_cmp++;
        if (sample_data !== 16'sd0 || env_state !== 2'd0 || sample_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL idle_sample: got data %0d env %0d valid %b want 0 0 1",
                   sample_data, env_state, sample_valid);
        end
      end
    end
  endtask

  task automatic test_attack_sustain();
    bit tk;
    int ticks;
    int last_flip;
    bit prev_pos;
    key_n[2] = 1'b0;
    repeat (5) step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd2 || env_state !== 2'd1) begin
      n_bad++;
      $display("FAIL attack_start: got key %0d env %0d want 2 1", cur_key, env_state);
    end
    ticks = 0;
    last_flip = -1;
    prev_pos = 1'b0;
    while (ticks < 256 + 230) begin
      gen_tick(tk);
      step(tk, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL attack_cycle: got %h want %h", obs_vec(), exp_vec());
      end
      if (tk) begin
        ticks++;
        if (ticks == 255) begin
          n_cmp++;
          if (env_state !== 2'd1) begin
            n_bad++;
            $display("FAIL attack_255: got env %0d want 1", env_state);
          end
        end
        if (ticks == 256) begin
          n_cmp++;
          if (env_state !== 2'd2 || (sample_data !== 16'sd16383 && sample_data !== -16'sd16383)) begin
            n_bad++;
            $display("FAIL sustain_reached: got env %0d data %0d want 2 +-16383", env_state, sample_data);
          end
        end
        if (ticks > 256) begin
          if (ticks > 257 && (sample_data > 0) != prev_pos) begin
            if (last_flip >= 0) begin
              n_cmp++;
              if (ticks - last_flip != 73) begin
                n_bad++;
                $display("FAIL flip_period: got %0d want 73", ticks - last_flip);
              end
            end
            last_flip = ticks;
          end
          prev_pos = (sample_data > 0);
        end
      end
    end
    key_n[2] = 1'b1;
    repeat (5) step(1'b0, 1'b1);
    ticks = 0;
    while (ticks < 256) begin
      gen_tick(tk);
      step(tk, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL release_cycle: got %h want %h", obs_vec(), exp_vec());
      end
      if (tk) ticks++;
      if (tk && ticks == 255) begin
        n_cmp++;
        if (env_state !== 2'd3) begin
          n_bad++;
          $display("FAIL release_255: got env %0d want 3", env_state);
        end
      end
    end
    n_cmp++;
    if (env_state !== 2'd0 || sample_data !== 16'sd0 || note_active !== 1'b0) begin
      n_bad++;
      $display("FAIL release_idle: got env %0d data %0d active %b want 0 0 0",
               env_state, sample_data, note_active);
    end
  endtask

  task automatic test_legato();
    bit tk;
    logic [1:0] env_before;
    key_n[0] = 1'b0;
    repeat (5) step(1'b0, 1'b1);
    for (int c = 0; c < 120; c++) begin
      gen_tick(tk);
      step(tk, 1'b1);
    end
    key_n[3] = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd0) begin
      n_bad++;
      $display("FAIL legato_latency_early: got key %0d want 0", cur_key);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd3) begin
      n_bad++;
      $display("FAIL legato_latency: got key %0d want 3", cur_key);
    end
    for (int c = 0; c < 600; c++) begin
      gen_tick(tk);
      step(tk, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL legato_cycle: got %h want %h", obs_vec(), exp_vec());
      end
    end
    env_before = env_state;
    key_n[3] = 1'b1;
    repeat (3) step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd0 || env_state !== env_before) begin
      n_bad++;
      $display("FAIL legato_return: got key %0d env %0d want 0 %0d", cur_key, env_state, env_before);
    end
    key_n[0] = 1'b1;
    repeat (3) step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd0 || env_state !== 2'd3) begin
      n_bad++;
      $display("FAIL legato_release: got key %0d env %0d want 0 3", cur_key, env_state);
    end
    for (int c = 0; c < 3000 && m_st != 0; c++) begin
      gen_tick(tk);
      step(tk, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL legato_tail: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (env_state !== 2'd0) begin
      n_bad++;
      $display("FAIL legato_idle_timeout: got env %0d want 0", env_state);
    end
  endtask

  task automatic test_overrun();
    bit tk;
    int ticks;
    logic signed [W-1:0] held;
    key_n[1] = 1'b0;
    repeat (5) step(1'b0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      gen_tick(tk);
      step(tk, 1'b1);
    end
    ticks = 0;
    while (ticks < 2) begin
      gen_tick(tk);
      step(tk, 1'b0);
      if (tk) ticks++;
      if (tk && ticks == 1) begin
        n_cmp++;
        if (overrun !== 1'b0 || sample_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL overrun_first: got ovr %b valid %b want 0 1", overrun, sample_valid);
        end
      end
    end
    n_cmp++;
    if (obs_vec() !== exp_vec() || overrun !== 1'b1 || sample_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_replace: got %h want %h", obs_vec(), exp_vec());
    end
    held = sample_data;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_cmp++;
    if (sample_data !== held || sample_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_stable: got %0d valid %b want %0d 1", sample_data, sample_valid, held);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_drop: got valid %b ovr %b want 0 1", sample_valid, overrun);
    end
    key_n[1] = 1'b1;
    repeat (4) step(1'b0, 1'b1);
  endtask

  task automatic test_simultaneous_and_reset();
    bit tk;
    key_n[2:1] = 2'b00;
    repeat (3) step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd2) begin
      n_bad++;
      $display("FAIL simultaneous_rise: got key %0d want 2", cur_key);
    end
    for (int c = 0; c < 3000 && m_st != 2; c++) begin
      gen_tick(tk);
      step(tk, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL simul_cycle: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (env_state !== 2'd2) begin
      n_bad++;
      $display("FAIL simul_sustain_timeout: got env %0d want 2", env_state);
    end
    resetn = 1'b0;
    #2;
    n_cmp++;
    if (obs_vec() !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_mid_note: got %h want 0", obs_vec());
    end
    model_reset();
    key_n = '1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_random();
    bit tk;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 39) == 0) key_n[$urandom_range(0, NK-1)] ^= 1'b1;
      gen_tick(tk);
      step(tk, $urandom_range(0, 3) != 0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    key_n = '1;
  endtask

`ifdef KEY_DEBOUNCE_EN
  task automatic test_debounce();
    key_n[1] = 1'b0;
    repeat (5) step(1'b0, 1'b1);
    key_n[1] = 1'b1;
    repeat (20) step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd0 || env_state !== 2'd0) begin
      n_bad++;
      $display("FAIL bounce_ignored: got key %0d env %0d want 0 0", cur_key, env_state);
    end
    key_n[1] = 1'b0;
    repeat (12) step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd0) begin
      n_bad++;
      $display("FAIL debounce_early: got key %0d want 0", cur_key);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (cur_key !== 2'd1 || env_state !== 2'd1) begin
      n_bad++;
      $display("FAIL debounce_event: got key %0d env %0d want 1 1", cur_key, env_state);
    end
    key_n = '1;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
`ifdef KEY_DEBOUNCE_EN
    test_debounce();
`else
    test_attack_sustain();
    test_legato();
    test_overrun();
    test_simultaneous_and_reset();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
